// File: rtl/seq_barrel_shifter.sv
// rtl/seq_barrel_shifter.sv - iterative barrel shifter, one 2:1 mux rank reused per stage
module seq_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_shamt;
  logic             r_dir;
  logic             r_fill;
  logic [SHW-1:0]   r_k;

  logic [SHW-1:0]   w_onehot;
  logic             w_sel;
  logic             w_last;
  logic [WIDTH-1:0] w_fill_mask;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_stage;

  // The one-hot stage select doubles as the stage's shift distance 2^k.
  assign w_onehot    = SHW'(1) << r_k;
  assign w_sel       = |(r_shamt & w_onehot);
  assign w_last      = (r_k == SHW'(SHW - 1));
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_onehot);
  assign w_left      = r_work << w_onehot;
  assign w_right     = (r_work >> w_onehot) | (r_fill ? w_fill_mask : '0);
  assign w_stage     = !w_sel ? r_work : (r_dir ? w_right : w_left);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work   <= '0;
      r_shamt  <= '0;
      r_dir    <= 1'b0;
      r_fill   <= 1'b0;
      r_k      <= '0;
      data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= data_in;
            r_shamt <= shamt;
            r_dir   <= dir;
            r_fill  <= dir & arith & data_in[WIDTH-1];
            r_k     <= '0;
          end
        end
        S_SHIFT: begin
          r_work <= w_stage;
          r_k    <= r_k + SHW'(1);
          // Only the final stage result is ever exposed on data_out.
          if (w_last) data_out <= w_stage;
        end
        default: ;
      endcase
    end
  end

endmodule
